// File: rtl/alu_flag_gen.sv
// Multi-cycle ALU: single-cycle ADD/SUB/AND/NOR, bit-serial shifts and rotates.
// Result and Z/V/N flags are registered and only change on entry to DONE.
module alu_flag_gen #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             z,
  output logic             v,
  output logic             n
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e           state_q, state_d;
  logic [1:0]       shop_q, shop_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             z_q, z_d, v_q, v_d, n_q, n_d;

  logic [WIDTH-1:0] sum, diff, alu_res, step, load_val;
  logic             alu_v, load_v, load_en;

  always_comb begin
    sum  = a + b;
    diff = a - b;
    alu_res = sum;
    alu_v   = 1'b0;
    case (op[1:0])
      2'b00: begin
        alu_res = sum;
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      2'b01: begin
        alu_res = diff;
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      2'b10:   alu_res = a & b;
      default: alu_res = ~(a | b);
    endcase
  end

  // One bit position per SHIFT cycle on the working register.
  always_comb begin
    case (shop_q)
      2'b00:   step = {work_q[WIDTH-2:0], 1'b0};
      2'b01:   step = {1'b0, work_q[WIDTH-1:1]};
      2'b10:   step = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      default: step = {work_q[0], work_q[WIDTH-1:1]};
    endcase
  end

  always_comb begin
    state_d  = state_q;
    shop_d   = shop_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    load_en  = 1'b0;
    load_val = '0;
    load_v   = 1'b0;
    case (state_q)
      SHIFT: begin
        work_d = step;
        cnt_d  = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          load_en  = 1'b1;
          load_val = step;
          state_d  = DONE;
        end
      end
      default: begin
        if (start) begin
          shop_d = op[1:0];
          if (!op[2]) begin
            load_en  = 1'b1;
            load_val = alu_res;
            load_v   = alu_v;
            state_d  = DONE;
          end else if (shamt == '0) begin
            load_en  = 1'b1;
            load_val = a;
            state_d  = DONE;
          end else begin
            work_d  = a;
            cnt_d   = shamt;
            state_d = SHIFT;
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase
    res_d = res_q;
    z_d   = z_q;
    v_d   = v_q;
    n_d   = n_q;
    if (load_en) begin
      res_d = load_val;
      z_d   = (load_val == '0);
      v_d   = load_v;
      n_d   = load_val[WIDTH-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shop_q  <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      z_q     <= 1'b0;
      v_q     <= 1'b0;
      n_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      shop_q  <= shop_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      z_q     <= z_d;
      v_q     <= v_d;
      n_q     <= n_d;
    end
  end

  assign busy   = (state_q == SHIFT);
  assign done   = (state_q == DONE);
  assign result = res_q;
  assign z      = z_q;
  assign v      = v_q;
  assign n      = n_q;

endmodule

// File: tb/tb_alu_flag_gen.sv
// Scoreboard bench for alu_flag_gen: expected {result,z,v,n} pushed at issue,
// popped and compared when done is observed.
module tb_alu_flag_gen;
  localparam int WIDTH = 16;
  localparam int SHW   = 4;
  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, NOR = 3'd3,
                         SLL = 3'd4, SRL = 3'd5, SRA = 3'd6, ROR = 3'd7;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [2:0]       op = '0;
  logic [WIDTH-1:0] a = '0, b = '0;
  logic [SHW-1:0]   shamt = '0;
  logic             busy, done, z, v, n;
  logic [WIDTH-1:0] result;

  int pass_cnt = 0;
  int total    = 0;
  logic [WIDTH+2:0] sb[$];

  alu_flag_gen #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .shamt(shamt),
    .busy(busy), .done(done), .result(result), .z(z), .v(v), .n(n)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH+2:0] model(input logic [2:0] o, input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y, input int sh);
    logic [WIDTH-1:0] r;
    logic ov;
    ov = 1'b0;
    case (o)
      ADD: begin r = x + y; ov = (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]); end
      SUB: begin r = x - y; ov = (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]); end
      AND_: r = x & y;
      NOR:  r = ~(x | y);
      SLL:  r = x << sh;
      SRL:  r = x >> sh;
      SRA:  r = WIDTH'($signed(x) >>> sh);
      default: begin
        r = x;
        for (int i = 0; i < sh; i++) r = {r[0], r[WIDTH-1:1]};
      end
    endcase
    return {r, (r == '0), ov, r[WIDTH-1]};
  endfunction

  task automatic issue(input logic [2:0] o, input logic [WIDTH-1:0] x,
                       input logic [WIDTH-1:0] y, input int sh);
    op = o; a = x; b = y; shamt = SHW'(sh); start = 1'b1;
    sb.push_back(model(o, x, y, sh));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Advances to the negedge where done is seen; no comparisons here.
  task automatic wait_done(input int lat0, output int lat, output int busy_n, output bit to);
    lat = lat0; busy_n = 0; to = 1'b0;
    while (done !== 1'b1) begin
      if (busy === 1'b1) busy_n++;
      if (lat >= 64) begin to = 1'b1; break; end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    #1;
    total++;
    if ({result, z, v, n, busy, done} !== '0)
      $display("FAIL reset: got %h required 0", {result, z, v, n, busy, done});
    else pass_cnt++;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({result, z, v, n, busy, done} !== '0)
      $display("FAIL reset_release_idle: got %h required 0", {result, z, v, n, busy, done});
    else pass_cnt++;
  endtask

  task automatic test_arith;
    logic [2:0]       ops[4] = '{ADD, SUB, NOR, AND_};
    logic [WIDTH-1:0] as[4]  = '{16'h7FFF, 16'h8000, 16'h00FF, 16'hF0F0};
    logic [WIDTH-1:0] bs[4]  = '{16'h0001, 16'h0001, 16'hFF00, 16'h3C3C};
    int lat, bn; bit to;
    logic [WIDTH+2:0] exp;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i], 0);
      wait_done(1, lat, bn, to);
      total++;
      if (to || lat != 1) $display("FAIL arith%0d_latency: got %0d required 1", i, lat);
      else pass_cnt++;
      exp = sb.pop_front();
      total++;
      if ({result, z, v, n} !== exp)
        $display("FAIL arith%0d_value: got %h/%b%b%b required %h/%b", i, result, z, v, n,
                 exp[WIDTH+2:3], exp[2:0]);
      else pass_cnt++;
      @(negedge clk);
    end
    // Spot-check against the hand-derived value for ADD 0x7FFF+1.
    issue(ADD, 16'h7FFF, 16'h0001, 0);
    void'(sb.pop_front());
    total++;
    if ({done, result, z, v, n} !== {1'b1, 16'h8000, 3'b011})
      $display("FAIL add_ovf_const: got %b %h %b%b%b required 1 8000 011", done, result, z, v, n);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [WIDTH+2:0] exp;
    issue(SUB, 16'h1234, 16'h1234, 0);
    exp = sb.pop_front();
    total++;
    if (done !== 1'b1 || {result, z, v, n} !== exp || exp !== {16'h0000, 3'b100})
      $display("FAIL b2b_sub: got %b %h %b%b%b required 1 0000 100", done, result, z, v, n);
    else pass_cnt++;
    issue(AND_, 16'h00F0, 16'h0F00, 0);
    exp = sb.pop_front();
    total++;
    if (done !== 1'b1 || {result, z, v, n} !== exp)
      $display("FAIL b2b_and: got %b %h %b%b%b required 1 %h %b", done, result, z, v, n,
               exp[WIDTH+2:3], exp[2:0]);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (done !== 1'b0) $display("FAIL b2b_single_pulse: got done=%b required 0", done);
    else pass_cnt++;
  endtask

  task automatic test_shift;
    int lat, bn; bit to;
    logic [WIDTH+2:0] exp;
    logic [2:0]       ops[4] = '{ROR, SLL, SRL, SLL};
    logic [WIDTH-1:0] as[4]  = '{16'h0001, 16'hFFFF, 16'hFFFF, 16'h8421};
    int               shs[4] = '{15, 0, 15, 5};
    // SRA with a start pulse during busy that must be ignored.
    issue(SRA, 16'h8001, 16'h0000, 3);
    total++;
    if (busy !== 1'b1) $display("FAIL sra_busy_t1: got %b required 1", busy);
    else pass_cnt++;
    op = ADD; a = 16'h0001; b = 16'h0001; shamt = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(2, lat, bn, to);
    total++;
    if (to || lat != 4 || bn != 2)
      $display("FAIL sra_timing: got lat=%0d busy=%0d required lat=4 busy=3", lat, bn + 1);
    else pass_cnt++;
    exp = sb.pop_front();
    total++;
    if ({result, z, v, n} !== exp || exp !== {16'hF000, 3'b001})
      $display("FAIL sra_value: got %h %b%b%b required f000 001", result, z, v, n);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL sra_ignored_start: got done=%b busy=%b required 0 0", done, busy);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], 16'hAAAA, shs[i]);
      wait_done(1, lat, bn, to);
      total++;
      if (to || lat != shs[i] + 1)
        $display("FAIL shift%0d_latency: got %0d required %0d", i, lat, shs[i] + 1);
      else pass_cnt++;
      exp = sb.pop_front();
      total++;
      if ({result, z, v, n} !== exp)
        $display("FAIL shift%0d_value: got %h %b%b%b required %h %b", i, result, z, v, n,
                 exp[WIDTH+2:3], exp[2:0]);
      else pass_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_shift;
    int lat, bn, seen; bit to;
    logic [WIDTH+2:0] exp;
    issue(SRL, 16'hF0F0, 16'h0000, 10);
    @(negedge clk); @(negedge clk); @(negedge clk);
    total++;
    if (busy !== 1'b1) $display("FAIL rst_mid_busy: got %b required 1", busy);
    else pass_cnt++;
    rst = 1'b1;
    #1;
    total++;
    if ({result, z, v, n, busy, done} !== '0)
      $display("FAIL rst_mid_outputs: got %h required 0", {result, z, v, n, busy, done});
    else pass_cnt++;
    void'(sb.pop_front());
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    total++;
    if (seen != 0) $display("FAIL rst_mid_no_done: got %0d active cycles required 0", seen);
    else pass_cnt++;
    issue(ADD, 16'd2, 16'd3, 0);
    wait_done(1, lat, bn, to);
    exp = sb.pop_front();
    total++;
    if (to || lat != 1 || {result, z, v, n} !== exp || result !== 16'd5)
      $display("FAIL rst_then_add: got lat=%0d %h required lat=1 0005", lat, result);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_flag_hold;
    int lat, bn, bad; bit to;
    logic [WIDTH+2:0] exp;
    issue(ADD, 16'h8000, 16'h8000, 0);
    wait_done(1, lat, bn, to);
    exp = sb.pop_front();
    total++;
    if (to || {result, z, v, n} !== exp || exp !== {16'h0000, 3'b110})
      $display("FAIL hold_add: got %h %b%b%b required 0000 110", result, z, v, n);
    else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || {result, z, v, n} !== exp) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL hold_idle: got %0d changed cycles required 0", bad);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_arith();
    test_back_to_back();
    test_shift();
    test_reset_mid_shift();
    test_flag_hold();
    total++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d left required 0", sb.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
